peak_detect: RTL and testbench

//  Upstream of the weighting/DOA stage. After the FFT frame is written to the reference-channel FFT_RAM,

---
 rtl/doa_pkg.sv | 24 ++
 rtl/peak_detect_if.sv | 36 +++
 rtl/mag_sq.sv | 38 +++
 rtl/peak_detect.sv | 144 ++++++++++++++
 tb/tb_peak_detect.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/doa_pkg.sv
// Shared DOA-path types and sizes. Imported by peak_detect and weightblock.
package doa_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned FFT_W  = 14;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } fft_word_t;

  // |X|^2 never exceeds 2*2^(2*FFT_W-2), so 2*FFT_W bits hold it unsigned.
  typedef logic [2*FFT_W-1:0] mag_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } pd_state_t;

endpackage

// File: rtl/peak_detect_if.sv
// FFT_RAM read port and peak result bundle for peak_detect.
// Optional PEAK_THRESH_EN adds thresh/nodetect.
interface peak_detect_if;
  import doa_pkg::*;

  logic      start;
  fft_word_t ramq;
  addr_t     rdaddr;
  logic      busy;
  logic      detectdone;
  addr_t     maxbin;
  mag_t      maxmag;
`ifdef PEAK_THRESH_EN
  mag_t      thresh;
  logic      nodetect;
`endif

  modport master (
`ifdef PEAK_THRESH_EN
    output thresh,
    input  nodetect,
`endif
    output start, ramq,
    input  rdaddr, busy, detectdone, maxbin, maxmag
  );

  modport slave (
`ifdef PEAK_THRESH_EN
    input  thresh,
    output nodetect,
`endif
    input  start, ramq,
    output rdaddr, busy, detectdone, maxbin, maxmag
  );

endinterface

// File: rtl/mag_sq.sv
// Registered |X|^2 = re^2 + im^2 with one clock of latency; valid and bin tag ride along.
module mag_sq
  import doa_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  fft_word_t word,
  input  logic      word_valid,
  input  addr_t     word_tag,
  output mag_t      mag,
  output logic      mag_valid,
  output addr_t     mag_tag
);

  logic signed [2*FFT_W-1:0] re_x, im_x, re_sq, im_sq;
  mag_t mag_d;

  always_comb begin
    re_x  = {{FFT_W{word.re[FFT_W-1]}}, word.re};
    im_x  = {{FFT_W{word.im[FFT_W-1]}}, word.im};
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    mag_d = mag_t'(re_sq) + mag_t'(im_sq);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag       <= '0;
      mag_valid <= 1'b0;
      mag_tag   <= '0;
    end else begin
      mag       <= mag_d;
      mag_valid <= word_valid;
      mag_tag   <= word_tag;
    end
  end

endmodule

// File: rtl/peak_detect.sv
// Scans FFT_RAM bins BIN_LO..BIN_HI and reports the strongest bin and its |X|^2.
// Define PEAK_THRESH_EN to gate detectdone with a minimum-magnitude threshold (nodetect).
module peak_detect
  import doa_pkg::*;
#(
  parameter int unsigned BIN_LO = 1,
  parameter int unsigned BIN_HI = 511,
  parameter int unsigned RD_LAT = 2
) (
  input logic          clk,
  input logic          reset,
  peak_detect_if.slave bus
);

  // Drain covers RAM latency, the mag_sq register and the compare register.
  localparam int unsigned DRAIN_CYC = RD_LAT + 2;
  localparam int unsigned CNT_W     = $clog2(DRAIN_CYC + 1);
  localparam addr_t       BIN_LO_A  = addr_t'(BIN_LO);
  localparam addr_t       BIN_HI_A  = addr_t'(BIN_HI);

  pd_state_t        state_q, state_d;
  addr_t            rdaddr_q, rdaddr_d;
  logic [CNT_W-1:0] drain_q, drain_d;
  mag_t             best_q, best_d;
  addr_t            bestbin_q, bestbin_d;
  mag_t             maxmag_q, maxmag_d;
  addr_t            maxbin_q, maxbin_d;

  logic [RD_LAT-1:0] vld_q;
  addr_t             tag_q [RD_LAT];

  mag_t  mag;
  logic  mag_valid;
  addr_t mag_tag;
  logic  done;

  mag_sq u_mag_sq (
    .clk        (clk),
    .reset      (reset),
    .word       (bus.ramq),
    .word_valid (vld_q[RD_LAT-1]),
    .word_tag   (tag_q[RD_LAT-1]),
    .mag        (mag),
    .mag_valid  (mag_valid),
    .mag_tag    (mag_tag)
  );

  always_comb begin
    state_d   = state_q;
    rdaddr_d  = rdaddr_q;
    drain_d   = drain_q;
    best_d    = best_q;
    bestbin_d = bestbin_q;
    maxmag_d  = maxmag_q;
    maxbin_d  = maxbin_q;

    // Bins arrive in ascending order, so strict > keeps the lower bin on ties.
    if (mag_valid && (mag > best_q)) begin
      best_d    = mag;
      bestbin_d = mag_tag;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StScan;
          rdaddr_d  = BIN_LO_A;
          best_d    = '0;
          bestbin_d = BIN_LO_A;
        end
      end
      StScan: begin
        if (rdaddr_q == BIN_HI_A) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          rdaddr_d = rdaddr_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == CNT_W'(DRAIN_CYC - 1)) begin
          state_d  = StDone;
          maxbin_d = bestbin_q;
          maxmag_d = best_q;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rdaddr_q  <= BIN_LO_A;
      drain_q   <= '0;
      best_q    <= '0;
      bestbin_q <= BIN_LO_A;
      maxmag_q  <= '0;
      maxbin_q  <= '0;
    end else begin
      state_q   <= state_d;
      rdaddr_q  <= rdaddr_d;
      drain_q   <= drain_d;
      best_q    <= best_d;
      bestbin_q <= bestbin_d;
      maxmag_q  <= maxmag_d;
      maxbin_q  <= maxbin_d;
    end
  end

  // Valid/tag shift register tracks each issued address through the RAM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= (state_q == StScan);
      tag_q[0] <= rdaddr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign done       = (state_q == StDone);
  assign bus.rdaddr = rdaddr_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.maxbin = maxbin_q;
  assign bus.maxmag = maxmag_q;

`ifdef PEAK_THRESH_EN
  logic below;
  assign below          = (best_q < bus.thresh);
  assign bus.detectdone = done & ~below;
  assign bus.nodetect   = done & below;
`else
  assign bus.detectdone = done;
`endif

endmodule

// File: tb/tb_peak_detect.sv
// Self-checking bench for peak_detect: directed frames plus random frames vs a reference scan.
module tb_peak_detect;
  import doa_pkg::*;

  localparam int BIN_LO = 1;
  localparam int BIN_HI = 511;
  localparam int RD_LAT = 2;
  localparam int LAT    = (BIN_HI - BIN_LO + 1) + RD_LAT + 2;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  fft_word_t mem [1024];
  fft_word_t r1;

  peak_detect_if bus ();

  peak_detect #(
    .BIN_LO (BIN_LO),
    .BIN_HI (BIN_HI),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // FFT_RAM model with two clocks of read latency.
  always @(posedge clk) begin
    r1       <= mem[bus.rdaddr];
    bus.ramq <= r1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_bin(input int b, input int re, input int im);
    mem[b].re = FFT_W'(re);
    mem[b].im = FFT_W'(im);
  endtask

  task automatic fill_const(input int re, input int im);
    for (int b = 0; b < 1024; b++) set_bin(b, re, im);
  endtask

  task automatic fill_rand(input int span);
    for (int b = 0; b < 1024; b++) begin
      if (span == 0) begin
        mem[b].re = FFT_W'($urandom);
        mem[b].im = FFT_W'($urandom);
      end else begin
        set_bin(b, int'($urandom_range(0, 2 * span)) - span,
                int'($urandom_range(0, 2 * span)) - span);
      end
    end
  endtask

  // Reference: first bin in the scan range holding the largest re^2+im^2.
  task automatic ref_peak(output int bin, output longint mag);
    longint re, im, m;
    bin = BIN_LO;
    mag = 0;
    for (int b = BIN_LO; b <= BIN_HI; b++) begin
      re = longint'(mem[b].re);
      im = longint'(mem[b].im);
      m  = re * re + im * im;
      if (m > mag) begin
        mag = m;
        bin = b;
      end
    end
  endtask

  // Pulses start, then waits (bounded) for detectdone or nodetect; extra starts at x1..x3.
  task automatic run_scan(input int x1, input int x2, input int x3,
                          output int lat, output bit busy_ok, output bit dd, output bit nd);
    lat     = -1;
    busy_ok = 1'b1;
    dd      = 1'b0;
    nd      = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      bus.start = (i == x1) || (i == x2) || (i == x3);
      dd = bus.detectdone;
`ifdef PEAK_THRESH_EN
      nd = bus.nodetect;
`endif
      if (dd || nd) begin
        lat = i;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  task automatic scan_check(input string name, input int exp_bin, input longint exp_mag,
                            input int x1, input int x2, input int x3);
    int     lat, rbin;
    bit     busy_ok, dd, nd;
    longint rmag;
    ref_peak(rbin, rmag);
    run_scan(x1, x2, x3, lat, busy_ok, dd, nd);
    check({name, ".latency"}, 64'(lat), 64'(LAT));
    check({name, ".busy"}, 64'(busy_ok), 64'd1);
    check({name, ".detectdone"}, 64'(dd), 64'd1);
    check({name, ".maxbin_ref"}, 64'(bus.maxbin), 64'(rbin));
    check({name, ".maxmag_ref"}, 64'(bus.maxmag), 64'(rmag));
    if (exp_bin >= 0) begin
      check({name, ".maxbin"}, 64'(bus.maxbin), 64'(exp_bin));
      check({name, ".maxmag"}, 64'(bus.maxmag), 64'(exp_mag));
    end
    @(negedge clk);
    check({name, ".pulse_width"}, 64'(bus.detectdone), 64'd0);
    check({name, ".busy_clear"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    bit bad;
    reset     = 1'b1;
    bus.start = 1'b0;
`ifdef PEAK_THRESH_EN
    bus.thresh = '0;
`endif
    fill_const(0, 0);
    repeat (3) @(negedge clk);
    check("rst.rdaddr", 64'(bus.rdaddr), 64'(BIN_LO));
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.detectdone", 64'(bus.detectdone), 64'd0);
    check("rst.maxbin", 64'(bus.maxbin), 64'd0);
    check("rst.maxmag", 64'(bus.maxmag), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    fill_const(0, 0);
    scan_check("zero", BIN_LO, 0, -1, -1, -1);

    fill_const(3, -4);
    set_bin(44, -226, -310);
    scan_check("peak44", 44, 147176, -1, -1, -1);

    fill_const(0, 0);
    set_bin(30, 338, -175);
    set_bin(50, 338, -175);
    scan_check("tie", 30, 144869, -1, -1, -1);

    fill_const(0, 0);
    set_bin(0, 8000, -8000);
    set_bin(512, -8000, 8000);
    set_bin(511, 100, 0);
    scan_check("edge", 511, 10000, -1, -1, -1);

    // Reset partway through a scan.
    fill_const(3, -4);
    set_bin(44, -226, -310);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.detectdone", 64'(bus.detectdone), 64'd0);
    check("abort.maxbin", 64'(bus.maxbin), 64'd0);
    check("abort.maxmag", 64'(bus.maxmag), 64'd0);
    check("abort.rdaddr", 64'(bus.rdaddr), 64'(BIN_LO));
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (bus.detectdone !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    check("abort.quiet", 64'(bad), 64'd0);
    scan_check("restart", 44, 147176, -1, -1, -1);

    // Extra starts mid-scan, just before DONE and during DONE.
    scan_check("extra", 44, 147176, 10, 514, 515);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.detectdone !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    check("extra.no_rescan", 64'(bad), 64'd0);

    for (int k = 0; k < 3; k++) begin
      fill_rand(0);
      scan_check($sformatf("rand%0d", k), -1, 0, -1, -1, -1);
    end
    for (int k = 0; k < 2; k++) begin
      fill_rand(2);
      scan_check($sformatf("small%0d", k), -1, 0, -1, -1, -1);
    end

`ifdef PEAK_THRESH_EN
    begin
      int lat;
      bit busy_ok, dd, nd;
      fill_const(3, -4);
      set_bin(44, -226, -310);
      bus.thresh = 28'd200000;
      run_scan(-1, -1, -1, lat, busy_ok, dd, nd);
      check("thr_hi.latency", 64'(lat), 64'(LAT));
      check("thr_hi.nodetect", 64'(nd), 64'd1);
      check("thr_hi.detectdone", 64'(dd), 64'd0);
      check("thr_hi.maxbin", 64'(bus.maxbin), 64'd44);
      check("thr_hi.maxmag", 64'(bus.maxmag), 64'd147176);
      @(negedge clk);
      check("thr_hi.pulse_width", 64'(bus.nodetect), 64'd0);
      bus.thresh = 28'd147176;
      run_scan(-1, -1, -1, lat, busy_ok, dd, nd);
      check("thr_eq.detectdone", 64'(dd), 64'd1);
      check("thr_eq.nodetect", 64'(nd), 64'd0);
      check("thr_eq.maxbin", 64'(bus.maxbin), 64'd44);
      @(negedge clk);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
